// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-segment decode for the seven-segment scanner.
// Segment vectors are active-low and ordered {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Glyphs for 0..9, A, b, C, d, E, F (active-low).
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver. Each digit slot opens
// with one all-dark cycle to hide ghosting while anode and segments switch.
// Data is double-buffered: writes land in a pending register that is copied
// to the displayed (active) register only at the start of digit 0's slot.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_en,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lzb_en,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int PCNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [PCNT_W-1:0]       pcnt_q, pcnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] act_q, act_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, tick_d;

  logic                  frame_start;
  logic                  lit;
  logic [NUM_DIGITS-1:0] zero_above;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_zero;
  logic                  cur_blank;
  logic [6:0]            dec_seg;

  assign frame_start = (pcnt_q == '0) && (idx_q == '0);
  assign lit         = (pcnt_q != '0);

  // Prescaler and digit index; the index steps when the prescaler wraps.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    pcnt_d = pcnt_q + 1'b1;
    idx_d  = idx_q;
    if (pcnt_q == PCNT_LAST) begin
      pcnt_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Shadow buffering: the copy reads the pre-edge pending value, so a load
  // coinciding with the copy waits for the following frame.
  always_comb begin
    pend_d = load_en ? load_data : pend_q;
    act_d  = frame_start ? pend_q : act_q;
  end

  // For each digit, flag whether it and every more-significant digit are zero.
  always_comb begin
    logic run;
    run        = 1'b1;
    zero_above = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run           = run & (act_q[i*4 +: 4] == 4'h0);
      zero_above[i] = run;
    end
  end

  // Select nibble, decimal point and zero flag of the digit being scanned.
  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_zero = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib  = act_q[i*4 +: 4];
        cur_dp   = dp_in[i];
        cur_zero = zero_above[i];
      end
    end
  end

  // Digit 0 is never blanked so a zero value still shows "0".
  assign cur_blank = lzb_en && (idx_q != '0) && cur_zero;

  seg_hex_decode u_dec (
    .nibble_i (cur_nib),
    .seg_n_o  (dec_seg)
  );

  // Next output values: dark on the slot's first cycle, digit idx otherwise.
  always_comb begin
    seg_d  = SEG_BLANK;
    dp_d   = 1'b1;
    an_d   = '1;
    tick_d = frame_start;
    if (lit) begin
      seg_d = cur_blank ? SEG_BLANK : dec_seg;
      dp_d  = ~cur_dp;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) an_d[i] = 1'b0;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: the reset is sampled only at the clock edge here; it is not in the sensitivity list.
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      pcnt_q <= '0;
      idx_q  <= '0;
      pend_q <= '0;
      act_q  <= '0;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      an_q   <= '1;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end

  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign an_n       = an_q;
  assign frame_tick = tick_q;

endmodule
